cte_sched: RTL and testbench

CTE_SCHED -- requirements
Module: cte_sched

---
 rtl/cte_sched_pkg.sv | 20 ++
 rtl/cte_sched_rr_arbiter.sv | 33 +++
 rtl/cte_sched.sv | 107 ++++++++++
 tb/tb_cte_sched.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cte_sched_pkg.sv
// rtl/cte_sched_pkg.sv - shared types and defaults for the counter-enable scheduler
package cte_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int NREQ_DEF = 4;
   localparam int LENW_DEF = 3;
   localparam int CW_DEF   = 2;

   // Index width that stays legal for a single requester.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cte_sched_rr_arbiter.sv
// rtl/cte_sched_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
   import cte_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] onehot,
   output logic [IW-1:0]   index,
   output logic            valid
);

   always_comb begin
      int j;
      j      = 0;
      onehot = '0;
      index  = '0;
      valid  = 1'b0;
      // Walk from ptr upward, wrapping; ptr is always below NREQ.
      for (int off = 0; off < NREQ; off++) begin
         j = int'(ptr) + off;
         if (j >= NREQ) j = j - NREQ;
         if (!valid && req[j]) begin
            valid     = 1'b1;
            onehot[j] = 1'b1;
            index     = IW'(j);
         end
      end
   end

endmodule

// File: rtl/cte_sched.sv
// rtl/cte_sched.sv - grants a shared counter to one requester for a burst of len counts
module cte_sched
   import cte_sched_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int LENW = LENW_DEF,
   parameter int CW   = CW_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*LENW-1:0] req_len,
   input  logic [CW-1:0]        cnt,
   output logic [NREQ-1:0]      gnt,
   output logic                 cte,
   output logic                 cnt_clr,
   output logic [NREQ-1:0]      done,
   output logic                 abort,
   output logic                 wrap
);

   localparam int IW = idx_w(NREQ);

   state_t           state, state_nx;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    win;
   logic [NREQ-1:0]  win_oh;
   logic [LENW-1:0]  rem;
   logic             aborted;

   logic [NREQ-1:0]  arb_onehot;
   logic [IW-1:0]    arb_index;
   logic             arb_valid;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req    (req),
      .ptr    (ptr),
      .onehot (arb_onehot),
      .index  (arb_index),
      .valid  (arb_valid)
   );

   // Falling-edge state so the shared counter sees stable enables at its own edge.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= '0;
         win     <= '0;
         win_oh  <= '0;
         rem     <= '0;
         aborted <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  win     <= arb_index;
                  win_oh  <= arb_onehot;
                  rem     <= req_len[arb_index*LENW +: LENW];
                  aborted <= 1'b0;
               end
            end
            RUN: begin
               rem <= rem - LENW'(1);
               if (!req[win]) aborted <= 1'b1;
            end
            DONE: begin
               ptr <= (win == IW'(NREQ - 1)) ? '0 : win + IW'(1);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      gnt      = '0;
      cte      = 1'b0;
      cnt_clr  = 1'b0;
      done     = '0;
      abort    = 1'b0;
      case (state)
         IDLE: begin
            if (arb_valid) state_nx = GRANT;
         end
         GRANT: begin
            gnt      = win_oh;
            cnt_clr  = 1'b1;
            state_nx = (rem == '0) ? DONE : RUN;
         end
         RUN: begin
            gnt = win_oh;
            cte = req[win];
            if (!req[win] || rem == LENW'(1)) state_nx = DONE;
         end
         DONE: begin
            done     = win_oh;
            abort    = aborted;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign wrap = cte & (&cnt);

endmodule

// File: tb/tb_cte_sched.sv
// tb/tb_cte_sched.sv - self-checking bench for cte_sched
module tb_cte_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [11:0] req_len;
   logic [1:0]  cnt;
   logic [3:0]  gnt;
   logic        cte;
   logic        cnt_clr;
   logic [3:0]  done;
   logic        abort;
   logic        wrap;

   always #5 clk = ~clk;

   cte_sched #(.NREQ(4), .LENW(3), .CW(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .req_len (req_len),
      .cnt     (cnt),
      .gnt     (gnt),
      .cte     (cte),
      .cnt_clr (cnt_clr),
      .done    (done),
      .abort   (abort),
      .wrap    (wrap)
   );

   // Shared counter the scheduler drives.
   always @(negedge clk or posedge reset) begin
      if (reset)        cnt <= 2'd0;
      else if (cnt_clr) cnt <= 2'd0;
      else if (cte)     cnt <= cnt + 2'd1;
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
      end
   endtask

   function automatic int oh2idx(input logic [3:0] v);
      int r;
      r = -1;
      if ($countones(v) == 1)
         for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   task automatic burst(input int idx, input int len);
      bit got;
      req_len[idx*3 +: 3] = 3'(len);
      req = 4'(1 << idx);
      got = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(posedge clk);
         if (done != 0) begin
            got = 1'b1;
            req = '0;
         end
      end
      chk("burst done seen", int'(got), 1);
      @(posedge clk);
   endtask

   typedef struct {
      int idx;
      int len;
      int exp_gnt;
      int exp_cte;
      int exp_cnt;
      int exp_wrap_at;
      int exp_busy;
   } vec_t;

   typedef struct packed {
      logic [3:0] gnt;
      logic       cte;
      logic       cnt_clr;
      logic [3:0] done;
      logic       abort;
   } exp_t;

   vec_t tbl[5];
   int   order[5];
   int   exp_ord[5];
   int   g, cn, wa, busy, clrn, dn, ab, fc, ng, dn_cnt, nte, mptr, w, ln;
   bit   got, seen, bad_done, was_done, popped;
   exp_t q[$];
   exp_t e, t;
   logic ew;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{0, 3, 1, 3, 3, 0, 5};
      tbl[1] = '{2, 5, 4, 5, 1, 4, 7};
      tbl[2] = '{1, 0, 2, 0, 0, 0, 2};
      tbl[3] = '{3, 1, 8, 1, 1, 0, 3};
      tbl[4] = '{0, 7, 1, 7, 3, 4, 9};
      exp_ord = '{0, 1, 2, 3, 0};

      // Reset dominates even with every request high.
      reset = 1'b1;
      req = 4'b1111;
      req_len = 12'hfff;
      repeat (2) @(posedge clk);
      chk("reset outputs", int'({gnt, cte, cnt_clr, done, abort, wrap}), 0);
      req = '0;
      reset = 1'b0;

      // Contention: all four held, len 1 each.
      req_len = 12'b001_001_001_001;
      req = 4'b1111;
      ng = 0;
      dn_cnt = 0;
      for (int k = 0; k < 5; k++) order[k] = -1;
      for (int c = 0; c < 80 && dn_cnt < 5; c++) begin
         @(posedge clk);
         if (cnt_clr && ng < 5) begin
            order[ng] = oh2idx(gnt);
            ng++;
         end
         if (done != 0) begin
            dn_cnt++;
            if (dn_cnt == 5) req = '0;
         end
      end
      for (int k = 0; k < 5; k++) chk($sformatf("contention grant %0d", k), order[k], exp_ord[k]);
      chk("contention done count", dn_cnt, 5);
      @(posedge clk);

      // Single-request table.
      for (int ti = 0; ti < 5; ti++) begin
         g = 0; cn = 0; wa = 0; busy = 0; clrn = 0; dn = 0; ab = -1; fc = -1;
         got = 1'b0;
         req_len = '0;
         req_len[tbl[ti].idx*3 +: 3] = 3'(tbl[ti].len);
         req = 4'(1 << tbl[ti].idx);
         for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk);
            if (cnt_clr) begin
               g = int'(gnt);
               clrn++;
               req_len = 12'($urandom);
            end
            if (gnt != 0 || done != 0) busy++;
            if (cte) begin
               cn++;
               if (wrap) wa = cn;
            end else if (wrap) begin
               wa = 99;
            end
            if (done != 0) begin
               got = 1'b1;
               dn = int'(done);
               ab = int'(abort);
               fc = int'(cnt);
               req = '0;
            end
         end
         chk($sformatf("t%0d done seen", ti), int'(got), 1);
         chk($sformatf("t%0d gnt", ti), g, tbl[ti].exp_gnt);
         chk($sformatf("t%0d done", ti), dn, tbl[ti].exp_gnt);
         chk($sformatf("t%0d cnt_clr cycles", ti), clrn, 1);
         chk($sformatf("t%0d cte edges", ti), cn, tbl[ti].exp_cte);
         chk($sformatf("t%0d wrap position", ti), wa, tbl[ti].exp_wrap_at);
         chk($sformatf("t%0d final cnt", ti), fc, tbl[ti].exp_cnt);
         chk($sformatf("t%0d abort", ti), ab, 0);
         chk($sformatf("t%0d busy cycles", ti), busy, tbl[ti].exp_busy);
         @(posedge clk);
         chk($sformatf("t%0d idle after", ti), int'({gnt, cte, cnt_clr, done, abort, wrap}), 0);
      end

      // Abort: requester 1 drops after two counted edges.
      req_len = '0;
      req_len[5:3] = 3'd7;
      req = 4'b0010;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(posedge clk);
         if (cnt_clr) seen = 1'b1;
      end
      chk("abort grant seen", int'(seen), 1);
      nte = 0;
      for (int c = 0; c < 10 && nte < 2; c++) begin
         @(posedge clk);
         if (cte) nte++;
      end
      @(posedge clk);
      req = '0;
      #1;
      chk("abort cte drops", int'(cte), 0);
      chk("abort gnt held", int'(gnt), 2);
      @(posedge clk);
      chk("abort done", int'(done), 2);
      chk("abort flag", int'(abort), 1);
      chk("abort cnt", int'(cnt), 2);
      @(posedge clk);
      chk("abort idle after", int'({gnt, cte, cnt_clr, done, abort, wrap}), 0);

      // Leaves ptr at 1 so the post-reset check depends on ptr being cleared.
      burst(0, 1);

      // Reset in the middle of a burst.
      req_len = '0;
      req_len[8:6] = 3'd7;
      req = 4'b0100;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(posedge clk);
         if (cte) seen = 1'b1;
      end
      chk("midrun reached run", int'(seen), 1);
      #2 reset = 1'b1;
      #1;
      chk("reset async outputs", int'({gnt, cte, cnt_clr, done, abort, wrap}), 0);
      req = 4'b0011;
      req_len = 12'b000_000_010_010;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         chk("held reset outputs", int'({gnt, cte, cnt_clr, done, abort, wrap}), 0);
      end
      reset = 1'b0;
      seen = 1'b0;
      bad_done = 1'b0;
      g = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(posedge clk);
         if (done != 0) bad_done = 1'b1;
         if (cnt_clr) begin
            seen = 1'b1;
            g = int'(gnt);
         end
      end
      chk("post-reset grant", g, 1);
      chk("no done across reset", int'(bad_done), 0);
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
         @(posedge clk);
         if (done != 0) begin
            got = 1'b1;
            req = '0;
         end
      end
      chk("post-reset burst done", int'(got), 1);

      // Random traffic against a burst-level model.
      reset = 1'b1;
      req = '0;
      req_len = '0;
      repeat (2) @(posedge clk);
      reset = 1'b0;
      mptr = 0;
      q.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge clk);
         popped = (q.size() > 0);
         if (popped) e = q.pop_front();
         else e = '0;
         was_done = (e.done != 0);
         ew = e.cte && (cnt == 2'b11);
         chk($sformatf("random cycle %0d", cyc),
             int'({gnt, cte, cnt_clr, done, abort, wrap}), int'({e, ew}));
         if (was_done) req = req & ~e.done;
         if (popped && !was_done) begin
            w = oh2idx(e.gnt);
            if (w >= 0) req_len[w*3 +: 3] = 3'($urandom);
         end
         for (int i = 0; i < 4; i++) begin
            if (!req[i] && !(was_done && e.done[i]) && $urandom_range(0, 3) == 0) begin
               req[i] = 1'b1;
               req_len[i*3 +: 3] = 3'($urandom_range(0, 7));
            end
         end
         if (q.size() == 0 && !was_done && req != 0) begin
            w = -1;
            for (int k = 0; k < 4; k++)
               if (w < 0 && req[(mptr + k) % 4]) w = (mptr + k) % 4;
            ln = int'(req_len[w*3 +: 3]);
            t = '0; t.gnt = 4'(1 << w); t.cnt_clr = 1'b1;
            q.push_back(t);
            for (int k = 0; k < ln; k++) begin
               t = '0; t.gnt = 4'(1 << w); t.cte = 1'b1;
               q.push_back(t);
            end
            t = '0; t.done = 4'(1 << w);
            q.push_back(t);
            mptr = (w + 1) % 4;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
